uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter. It replaces the fixed 8N1 transmitter that feeds the debug and PSRAM-test console path. Bytes are accepted through a write-enable/full handshake into an internal FIFO. Each frame is serialised with configurable data width, parity and stop-bit count, and consecutive frames go out back-to-back without idle gaps. Unlike the previous generation, the bit timer restarts at every frame start, so the start bit is always exactly one bit period long.

---
 rtl/uart_tx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO front end feeding a framer with configurable
// data width, parity and stop bits; frames are sent back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 27000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_BITS-1:0]              din,
  input  logic                              wr_en,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              tx_busy,
  output logic                              tx_p,
  output logic [2:0]                        state_o
);

  localparam int unsigned BIT_CLKS = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W    = $clog2(BIT_CLKS);
  localparam int unsigned LW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned BW       = $clog2(DATA_BITS);
  localparam bit          HAS_PAR  = (PARITY == 1) || (PARITY == 2);
  localparam bit          TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Write handshake: a word is taken on any rising edge where wr_en=1 and
  // full=0; with full=1 the word is silently dropped. There is no read port.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = wr_en && !full;
  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end, stop_last;

  assign bit_end   = (cnt_q == CNT_W'(BIT_CLKS - 1));
  assign stop_last = !TWO_STOP || stop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    // The bit timer runs in every non-idle state and restarts at each boundary.
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (PARITY == 1) ? ~(^head) : (^head);
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
            if (HAS_PAR) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!stop_last) begin
            stop_d = 1'b1;
          end else if (!empty) begin
            // Back-to-back: next start bit directly follows the last stop bit.
            pop     = 1'b1;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~(^head) : (^head);
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_p    = tx_q;
  assign tx_busy = (state_q != S_IDLE) || !empty;
  assign state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations share one random stimulus and
// are compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;

  logic       full0, busy0, tx0;
  logic [2:0] lvl0, st0;
  logic       full1, busy1, tx1;
  logic [2:0] lvl1, st1;
  logic       full2, busy2, tx2;
  logic [3:0] lvl2;
  logic [2:0] st2;

  always #5 clk = ~clk;

  // 8 data bits, parity mode 3 (no parity), 1 stop, 8 clocks/bit, depth 4
  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(8), .PARITY(3), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full0), .level(lvl0),
    .tx_busy(busy0), .tx_p(tx0), .state_o(st0));
  // 7 data bits, even parity, 2 stops, 8 clocks/bit, depth 4
  uart_tx_fifo #(.CLK_FREQ(8), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .din(din[6:0]), .wr_en(wr_en), .full(full1), .level(lvl1),
    .tx_busy(busy1), .tx_p(tx1), .state_o(st1));
  // 8 data bits, odd parity, 2 stops, 10/3 = 3 clocks/bit, depth 8
  uart_tx_fifo #(.CLK_FREQ(10), .BAUD(3), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u2 (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full2), .level(lvl2),
    .tx_busy(busy2), .tx_p(tx2), .state_o(st2));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: per instance a bounded word FIFO and the current frame as a bit list.
  int         m_bc [3] = '{8, 8, 3};
  int         m_db [3] = '{8, 7, 8};
  int         m_par[3] = '{3, 2, 1};
  int         m_sb [3] = '{1, 2, 2};
  int         m_dep[3] = '{4, 4, 8};
  logic [7:0] m_fq [3][8];
  int         m_head[3], m_cnt[3], m_pos[3], m_flen[3];
  bit         m_act[3];
  bit         m_fb [3][16];

  // Scoreboard for instance 0: bytes it accepted, matched by a line receiver.
  logic [7:0] exp_q[$];
  bit         rx_act;
  int         rx_t;
  logic [7:0] rx_byte;

  task automatic load_frame(int i, logic [7:0] d);
    int n;
    bit p;
    p = 1'b0;
    n = 0;
    m_fb[i][n] = 1'b0; n = n + 1;
    for (int j = 0; j < m_db[i]; j++) begin
      m_fb[i][n] = d[j];
      p = p ^ d[j];
      n = n + 1;
    end
    if (m_par[i] == 1 || m_par[i] == 2) begin
      m_fb[i][n] = (m_par[i] == 1) ? ~p : p;
      n = n + 1;
    end
    for (int s = 0; s < m_sb[i]; s++) begin
      m_fb[i][n] = 1'b1;
      n = n + 1;
    end
    m_flen[i] = n;
  endtask

  task automatic model_edge(bit r, bit w, logic [7:0] d);
    for (int i = 0; i < 3; i++) begin
      int  pre;
      bit  acc, start_new;
      if (r) begin
        m_head[i] = 0; m_cnt[i] = 0; m_act[i] = 1'b0; m_pos[i] = 0;
        continue;
      end
      pre       = m_cnt[i];
      acc       = w && (pre < m_dep[i]);
      start_new = 1'b0;
      if (m_act[i]) begin
        m_pos[i]++;
        if (m_pos[i] == m_flen[i] * m_bc[i]) begin
          m_act[i]  = 1'b0;
          start_new = (pre > 0);
        end
      end else begin
        start_new = (pre > 0);
      end
      if (start_new) begin
        load_frame(i, m_fq[i][m_head[i]]);
        m_head[i] = (m_head[i] + 1) % m_dep[i];
        m_cnt[i]--;
        m_act[i] = 1'b1;
        m_pos[i] = 0;
      end
      if (acc) begin
        m_fq[i][(m_head[i] + m_cnt[i]) % m_dep[i]] = d;
        m_cnt[i]++;
        if (i == 0) exp_q.push_back(d);
      end
    end
    if (r) exp_q.delete();
  endtask

  function automatic int dut_val(int i, int k);
    case (i)
      0: case (k) 0: return int'(tx0); 1: return int'(lvl0); 2: return int'(full0); default: return int'(busy0); endcase
      1: case (k) 0: return int'(tx1); 1: return int'(lvl1); 2: return int'(full1); default: return int'(busy1); endcase
      default: case (k) 0: return int'(tx2); 1: return int'(lvl2); 2: return int'(full2); default: return int'(busy2); endcase
    endcase
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int e_tx;
      e_tx = m_act[i] ? int'(m_fb[i][m_pos[i] / m_bc[i]]) : 1;
      chk($sformatf("tx%0d", i),    dut_val(i, 0), e_tx);
      chk($sformatf("level%0d", i), dut_val(i, 1), m_cnt[i]);
      chk($sformatf("full%0d", i),  dut_val(i, 2), int'(m_cnt[i] == m_dep[i]));
      chk($sformatf("busy%0d", i),  dut_val(i, 3), int'(m_act[i] || m_cnt[i] > 0));
    end
  endtask

  // Mid-bit sampling receiver on instance 0's line (8 clocks/bit, 8 data, 1 stop).
  task automatic rx_step(bit r);
    if (r) begin
      rx_act = 1'b0;
      return;
    end
    if (!rx_act) begin
      if (tx0 == 1'b0) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= 12 && rx_t <= 68 && (rx_t - 4) % 8 == 0)
        rx_byte[(rx_t - 12) / 8] = tx0;
      if (rx_t == 76) begin
        chk("rx0_stop", int'(tx0), 1);
        chk("rx0_queued", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("rx0_byte", int'(rx_byte), int'(exp_q.pop_front()));
        rx_act = 1'b0;
      end
    end
  endtask

  task automatic step(bit r, bit w, logic [7:0] d);
    @(negedge clk);
    rst = r; wr_en = w; din = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    compare_all();
    rx_step(r);
  endtask

  task automatic idle(int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; din = 8'h00;
    rx_act = 1'b0; rx_t = 0; rx_byte = 8'h00;
    for (int i = 0; i < 3; i++) begin
      m_head[i] = 0; m_cnt[i] = 0; m_pos[i] = 0; m_flen[i] = 0; m_act[i] = 1'b0;
    end
    repeat (3) step(1'b1, 1'b0, 8'h00);
    idle(2);

    step(1'b0, 1'b1, 8'hA5);
    idle(160);

    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b1, 8'hFF);
    idle(300);

    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'(8'h10 + k));
    idle(600);

    step(1'b0, 1'b1, 8'h55);
    idle(100);
    step(1'b0, 1'b1, 8'h07);
    idle(100);
    step(1'b0, 1'b1, 8'h03);
    idle(100);

    // Reset lands during the 4th data bit of instance 0 with two words still queued.
    step(1'b0, 1'b1, 8'h9B);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'hE4);
    idle(33);
    step(1'b1, 1'b0, 8'h00);
    idle(120);

    for (int blk = 0; blk < 20; blk++) begin
      int dens;
      dens = $urandom_range(1, 40);
      for (int c = 0; c < 200; c++) begin
        bit r, w;
        r = ($urandom_range(0, 1999) == 0);
        w = ($urandom_range(1, 40) <= dens / 4 + 1);
        step(r, w, 8'($urandom_range(0, 255)));
      end
    end
    idle(400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
